// File: rtl/baud_gen_frac_pkg.sv
// baud_gen_frac_pkg: reset defaults and 50 MHz divider presets shared by the register file and benches
package baud_gen_frac_pkg;

    localparam int BAUD_RST_FREQ  = 1152;
    localparam int BAUD_RST_LIMIT = 30098;

    typedef struct packed {
        logic [15:0] freq;
        logic [15:0] limit;
    } baud_preset_t;

    localparam baud_preset_t BAUD_9600_50M   = '{freq: 16'd48,   limit: 16'd15577};
    localparam baud_preset_t BAUD_115200_50M = '{freq: 16'd576,  limit: 16'd15049};
    // 4608/15625 is already reduced, so this preset needs FREQ_W >= 13
    localparam baud_preset_t BAUD_921600_50M = '{freq: 16'd4608, limit: 16'd11017};

endpackage

// File: rtl/baud_gen_frac_if.sv
// baud_gen_frac_if: configuration handshake between the register file and the baud generator
interface baud_gen_frac_if #(
    parameter int FREQ_W  = 12,
    parameter int LIMIT_W = 16
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic               cfg_err;
    logic [FREQ_W-1:0]  cfg_freq;
    logic [LIMIT_W-1:0] cfg_limit;

    modport master (output cfg_valid, cfg_freq, cfg_limit, input cfg_ready, cfg_err);
    modport slave  (input cfg_valid, cfg_freq, cfg_limit, output cfg_ready, cfg_err);
endinterface

// File: rtl/baud_gen_frac_nco.sv
// baud_nco: fractional accumulator; hit flags acc >= limit, where the next step subtracts instead of adding
module baud_nco #(
    parameter int FREQ_W  = 12,
    parameter int LIMIT_W = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               run,
    input  logic               clr,
    input  logic [FREQ_W-1:0]  freq,
    input  logic [LIMIT_W-1:0] limit,
    output logic               hit
);
    logic [LIMIT_W:0] acc;

    assign hit = acc >= {1'b0, limit};

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (run)
            acc <= hit ? acc - {1'b0, limit} : acc + (LIMIT_W+1)'(freq);
endmodule

// File: rtl/baud_gen_frac.sv
// baud_gen_frac: fractional baud generator with shadowed run-time reconfiguration and resync
module baud_gen_frac
    import baud_gen_frac_pkg::*;
#(
    parameter int FREQ_W    = 12,
    parameter int LIMIT_W   = 16,
    parameter int OSR       = 16,
    parameter int RST_FREQ  = BAUD_RST_FREQ,
    parameter int RST_LIMIT = BAUD_RST_LIMIT
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   resync,
    baud_gen_frac_if.slave         cfg,
    output logic                   ce_os,
    output logic                   ce_bit,
    output logic                   ce_mid,
    output logic [$clog2(OSR)-1:0] phase
);
    localparam int            PW   = $clog2(OSR);
    localparam logic [PW-1:0] LAST = PW'(OSR - 1);
    localparam logic [PW-1:0] MID  = PW'(OSR / 2 - 1);

    logic [FREQ_W-1:0]  act_freq, sh_freq;
    logic [LIMIT_W-1:0] act_limit, sh_limit;
    logic               pending, hit, apply, tick, xfer;

    assign cfg.cfg_ready = !pending;
    assign xfer  = cfg.cfg_valid && !pending;
    // swap only where the accumulator would wrap anyway, or when frozen
    assign apply = pending && (hit || !enable) && !resync;
    assign tick  = enable && hit && !resync && !apply;

    baud_nco #(.FREQ_W(FREQ_W), .LIMIT_W(LIMIT_W)) u_nco (
        .clock,
        .reset_n,
        .run   (enable),
        .clr   (resync || apply),
        .freq  (act_freq),
        .limit (act_limit),
        .hit
    );

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            pending     <= 1'b0;
            cfg.cfg_err <= 1'b0;
            sh_freq     <= '0;
            sh_limit    <= '0;
            act_freq    <= FREQ_W'(RST_FREQ);
            act_limit   <= LIMIT_W'(RST_LIMIT);
        end else begin
            cfg.cfg_err <= xfer && cfg.cfg_freq == '0;
            if (xfer && cfg.cfg_freq != '0) begin
                sh_freq  <= cfg.cfg_freq;
                sh_limit <= cfg.cfg_limit;
                pending  <= 1'b1;
            end else if (apply) begin
                act_freq  <= sh_freq;
                act_limit <= sh_limit;
                pending   <= 1'b0;
            end
        end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            phase  <= '0;
            ce_os  <= 1'b0;
            ce_bit <= 1'b0;
            ce_mid <= 1'b0;
        end else begin
            ce_os  <= tick;
            ce_bit <= tick && phase == LAST;
            ce_mid <= tick && phase == MID;
            if (resync || apply)
                phase <= '0;
            else if (tick)
                phase <= phase == LAST ? '0 : phase + 1'b1;
        end
endmodule

// File: tb/tb_baud_gen_frac.sv
// tb_baud_gen_frac: directed and randomized checks of baud_gen_frac against a cycle reference model
module tb_baud_gen_frac;
    localparam int OSR = 16;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       enable = 1'b0;
    logic       resync = 1'b0;
    logic       ce_os, ce_bit, ce_mid;
    logic [3:0] phase;
    int         n_cmp = 0;
    int         n_bad = 0;

    baud_gen_frac_if #(.FREQ_W(12), .LIMIT_W(16)) cfg_if ();

    baud_gen_frac dut (
        .clock, .reset_n, .enable, .resync,
        .cfg(cfg_if),
        .ce_os, .ce_bit, .ce_mid, .phase
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    int   m_acc = 0, m_f = 1152, m_l = 30098, m_sf = 0, m_sl = 0, m_ph = 0;
    logic m_pend = 1'b0, m_os = 1'b0, m_bit = 1'b0, m_mid = 1'b0, m_err = 1'b0;
    logic m_hit, m_apply, m_tick, m_xfer;

    assign m_hit   = m_acc >= m_l;
    assign m_apply = m_pend && (m_hit || !enable) && !resync;
    assign m_tick  = enable && !resync && !m_apply && m_hit;
    assign m_xfer  = cfg_if.cfg_valid && !m_pend;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_acc <= 0; m_f <= 1152; m_l <= 30098; m_sf <= 0; m_sl <= 0; m_ph <= 0;
            m_pend <= 1'b0; m_os <= 1'b0; m_bit <= 1'b0; m_mid <= 1'b0; m_err <= 1'b0;
        end else begin
            m_os  <= m_tick;
            m_bit <= m_tick && m_ph == OSR - 1;
            m_mid <= m_tick && m_ph == OSR / 2 - 1;
            m_err <= m_xfer && cfg_if.cfg_freq == 0;
            if (resync) begin
                m_acc <= 0;
                m_ph  <= 0;
            end else if (m_apply) begin
                m_acc <= 0;
                m_ph  <= 0;
                m_f   <= m_sf;
                m_l   <= m_sl;
            end else if (enable) begin
                m_acc <= m_hit ? m_acc - m_l : m_acc + m_f;
                if (m_tick) m_ph <= (m_ph + 1) % OSR;
            end
            if (m_xfer && cfg_if.cfg_freq != 0) begin
                m_sf   <= int'(cfg_if.cfg_freq);
                m_sl   <= int'(cfg_if.cfg_limit);
                m_pend <= 1'b1;
            end else if (m_apply) begin
                m_pend <= 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        chk("ce_os", 32'(ce_os), 32'(m_os));
        chk("ce_bit", 32'(ce_bit), 32'(m_bit));
        chk("ce_mid", 32'(ce_mid), 32'(m_mid));
        chk("phase", 32'(phase), 32'(m_ph));
        chk("cfg_ready", 32'(cfg_if.cfg_ready), 32'(!m_pend));
        chk("cfg_err", 32'(cfg_if.cfg_err), 32'(m_err));
    end

    task automatic offer(input int f, input int l);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_freq  = 12'(f);
        cfg_if.cfg_limit = 16'(l);
        @(negedge clock);
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 5000 && !cfg_if.cfg_ready; i++) @(negedge clock);
        chk("ready_timeout", 32'(cfg_if.cfg_ready), 1);
    endtask

    initial begin
        int cnt_os, cnt_bit, first_os, mid_at, bit_at, ph0, k;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_freq  = '0;
        cfg_if.cfg_limit = '0;
        enable = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_ready", 32'(cfg_if.cfg_ready), 1);
        chk("rst_ce_os", 32'(ce_os), 0);
        reset_n = 1'b1;

        cnt_os = 0;
        cnt_bit = 0;
        repeat (31250) begin
            @(negedge clock);
            cnt_os  += int'(ce_os);
            cnt_bit += int'(ce_bit);
        end
        chk("rst_os_count", 32'(cnt_os), 1152);
        chk("rst_bit_count", 32'(cnt_bit), 72);

        offer(1, 3);
        wait_ready();
        first_os = 0; mid_at = 0; bit_at = 0; cnt_os = 0;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clock);
            if (ce_os) begin
                cnt_os++;
                if (first_os == 0) first_os = i;
            end
            if (ce_mid && mid_at == 0) mid_at = i;
            if (ce_bit && bit_at == 0) bit_at = i;
        end
        chk("exact_first_os", 32'(first_os), 4);
        chk("exact_os_count", 32'(cnt_os), 16);
        chk("exact_mid_at", 32'(mid_at), 32);
        chk("exact_bit_at", 32'(bit_at), 64);

        offer(1, 1000);
        chk("pending_ready_low", 32'(cfg_if.cfg_ready), 0);
        offer(7, 9);
        wait_ready();

        offer(0, 5);
        chk("reject_err", 32'(cfg_if.cfg_err), 1);
        @(negedge clock);
        chk("reject_err_once", 32'(cfg_if.cfg_err), 0);
        chk("reject_ready", 32'(cfg_if.cfg_ready), 1);

        offer(1, 3);
        wait_ready();
        k = 0;
        while (k < 500 && phase != 4'd9) begin
            @(negedge clock);
            k++;
        end
        chk("reach_phase9", 32'(phase), 9);
        resync = 1'b1;
        @(negedge clock);
        resync = 1'b0;
        chk("resync_phase", 32'(phase), 0);
        bit_at = 0;
        for (int i = 1; i <= 200 && bit_at == 0; i++) begin
            @(negedge clock);
            if (ce_bit) bit_at = i;
        end
        chk("resync_bit_at", 32'(bit_at), 64);

        repeat (13) @(negedge clock);
        enable = 1'b0;
        ph0 = int'(phase);
        cnt_os = 0;
        repeat (50) begin
            @(negedge clock);
            cnt_os += int'(ce_os);
        end
        chk("gate_os", 32'(cnt_os), 0);
        chk("gate_phase", 32'(phase), 32'(ph0));
        enable = 1'b1;
        repeat (40) @(negedge clock);

        offer(3, 40);
        wait_ready();
        repeat (100) @(negedge clock);
        offer(2, 2);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_ce_os", 32'(ce_os), 0);
        chk("arst_ce_bit", 32'(ce_bit), 0);
        chk("arst_ce_mid", 32'(ce_mid), 0);
        chk("arst_phase", 32'(phase), 0);
        chk("arst_err", 32'(cfg_if.cfg_err), 0);
        chk("arst_ready", 32'(cfg_if.cfg_ready), 1);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        repeat (4000) begin
            @(negedge clock);
            enable           = $urandom_range(0, 15) != 0;
            resync           = $urandom_range(0, 40) == 0;
            cfg_if.cfg_valid = $urandom_range(0, 7) == 0;
            cfg_if.cfg_freq  = $urandom_range(0, 9) == 0 ? 12'd0 : 12'($urandom_range(1, 24));
            cfg_if.cfg_limit = 16'($urandom_range(0, 80));
        end
        @(negedge clock);
        cfg_if.cfg_valid = 1'b0;
        resync = 1'b0;
        enable = 1'b1;
        repeat (20) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
